// File: rtl/rsp_encoder.sv
// Response encoder: turns SDRAM read/write completions into ASCII frames
// ('D' + hex + EOL, 'K' + EOL) written byte-by-byte into the UART TX FIFO.
module rsp_encoder #(
    parameter int DATA_W = 16,
    parameter bit EOL_CR = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              wr_done,
    input  logic              tx_full,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    output logic              ready,
    output logic              overrun
);

    localparam int NIBS  = DATA_W / 4;
    localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DIG,
        S_CR,
        S_LF,
        S_GAP
    } state_t;

    localparam state_t EOL_ST = EOL_CR ? S_CR : S_LF;

    state_t             state, state_d;
    state_t             ret_state, ret_state_d;   // where GAP goes next
    logic               is_read, is_read_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               pending_wr, pending_wr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [7:0]         tx_data_d;
    logic               tx_wr_d;
    logic               overrun_d;

    logic [DATA_W-1:0]  data_sh;
    logic [3:0]         nib;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    // Current nibble, MSB first.
    assign data_sh = data_q << {cnt, 2'b00};
    assign nib     = data_sh[DATA_W-1 -: 4];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state      <= S_IDLE;
            ret_state  <= S_IDLE;
            is_read    <= 1'b0;
            cnt        <= '0;
            pending_wr <= 1'b0;
            data_q     <= '0;
            tx_data    <= 8'h00;
            tx_wr      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            ret_state  <= ret_state_d;
            is_read    <= is_read_d;
            cnt        <= cnt_d;
            pending_wr <= pending_wr_d;
            data_q     <= data_d;
            tx_data    <= tx_data_d;
            tx_wr      <= tx_wr_d;
            overrun    <= overrun_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a signal unassigned and infer a latch.
        state_d      = state;
        ret_state_d  = ret_state;
        is_read_d    = is_read;
        cnt_d        = cnt;
        pending_wr_d = pending_wr;
        data_d       = data_q;
        tx_data_d    = tx_data;
        tx_wr_d      = 1'b0;
        overrun_d    = overrun;

        case (state)
            S_IDLE: begin
                if (rd_valid) begin
                    data_d       = rd_data;
                    is_read_d    = 1'b1;
                    state_d      = S_HDR;
                    pending_wr_d = pending_wr | wr_done;
                    if (wr_done && pending_wr) overrun_d = 1'b1;
                end else if (pending_wr || wr_done) begin
                    is_read_d    = 1'b0;
                    state_d      = S_HDR;
                    pending_wr_d = pending_wr & wr_done;
                end
            end
            S_HDR: begin
                if (!tx_full) begin
                    tx_data_d   = is_read ? 8'h44 : 8'h4B;
                    tx_wr_d     = 1'b1;
                    cnt_d       = '0;
                    ret_state_d = is_read ? S_DIG : EOL_ST;
                    state_d     = S_GAP;
                end
            end
            S_DIG: begin
                if (!tx_full) begin
                    tx_data_d = hex_char(nib);
                    tx_wr_d   = 1'b1;
                    state_d   = S_GAP;
                    if (cnt == CNT_W'(NIBS - 1)) begin
                        ret_state_d = EOL_ST;
                    end else begin
                        ret_state_d = S_DIG;
                        cnt_d       = cnt + 1'b1;
                    end
                end
            end
            S_CR: begin
                if (!tx_full) begin
                    tx_data_d   = 8'h0D;
                    tx_wr_d     = 1'b1;
                    ret_state_d = S_LF;
                    state_d     = S_GAP;
                end
            end
            S_LF: begin
                if (!tx_full) begin
                    tx_data_d   = 8'h0A;
                    tx_wr_d     = 1'b1;
                    ret_state_d = S_IDLE;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                if (ret_state != S_IDLE) begin
                    state_d = ret_state;
                end else if (pending_wr) begin
                    pending_wr_d = 1'b0;
                    is_read_d    = 1'b0;
                    state_d      = S_HDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Completions arriving mid-frame: one write may queue, the rest is lost.
        if (state != S_IDLE) begin
            if (rd_valid) overrun_d = 1'b1;
            if (wr_done) begin
                if (pending_wr) overrun_d    = 1'b1;
                else            pending_wr_d = 1'b1;
            end
        end
    end

    assign ready = !reset && (state == S_IDLE) && !pending_wr;

endmodule

// File: tb/tb_rsp_encoder.sv
// Self-checking bench for rsp_encoder: byte scoreboards for a CR+LF and an
// LF-only instance, plus directed checks of flow control, overrun and reset.
module tb_rsp_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_valid = 1'b0;
    logic [15:0] rd_data = 16'h0;
    logic        wr_done = 1'b0;
    logic        tx_full = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        ready;
    logic        overrun;

    logic        rd_valid_b = 1'b0;
    logic [15:0] rd_data_b = 16'h0;
    logic        wr_done_b = 1'b0;
    logic        tx_full_b = 1'b0;
    logic [7:0]  tx_data_b;
    logic        tx_wr_b;
    logic        ready_b;
    logic        overrun_b;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b[$];
    logic       prev_wr = 1'b0;
    logic       prev_wr_b = 1'b0;

    always #5 clk = ~clk;

    rsp_encoder #(.DATA_W(16), .EOL_CR(1'b1)) dut (
        .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_done(wr_done), .tx_full(tx_full), .tx_data(tx_data), .tx_wr(tx_wr),
        .ready(ready), .overrun(overrun)
    );

    rsp_encoder #(.DATA_W(16), .EOL_CR(1'b0)) dut_lf (
        .clk(clk), .reset(reset), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
        .wr_done(wr_done_b), .tx_full(tx_full_b), .tx_data(tx_data_b), .tx_wr(tx_wr_b),
        .ready(ready_b), .overrun(overrun_b)
    );

    // Scoreboard monitors: every write strobe pops and compares one byte.
    always @(negedge clk) begin
        if (reset) begin
            prev_wr = 1'b0;
        end else begin
            if (tx_wr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte_unexpected: got %02h, expected no byte", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL byte: got %02h, expected %02h", tx_data, e);
                    end
                end
                checks++;
                if (prev_wr) begin
                    errors++;
                    $display("FAIL gap: tx_wr high two cycles in a row, expected a low cycle");
                end
            end
            prev_wr = tx_wr;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_wr_b = 1'b0;
        end else begin
            if (tx_wr_b) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL lf_byte_unexpected: got %02h, expected no byte", tx_data_b);
                end else begin
                    logic [7:0] e;
                    e = exp_b.pop_front();
                    if (tx_data_b !== e) begin
                        errors++;
                        $display("FAIL lf_byte: got %02h, expected %02h", tx_data_b, e);
                    end
                end
                checks++;
                if (prev_wr_b) begin
                    errors++;
                    $display("FAIL lf_gap: tx_wr high two cycles in a row");
                end
            end
            prev_wr_b = tx_wr_b;
        end
    end

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        string digits;
        digits = "0123456789ABCDEF";
        return digits[n];
    endfunction

    task automatic push_read(input logic [15:0] d);
        exp_q.push_back(8'h44);
        for (int i = 3; i >= 0; i--) exp_q.push_back(hex_ascii(d[i*4 +: 4]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic push_write();
        exp_q.push_back(8'h4B);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic pulse(input logic rd, input logic [15:0] d, input logic wr);
        @(posedge clk); #1;
        rd_valid = rd;
        rd_data  = d;
        wr_done  = wr;
        @(posedge clk); #1;
        rd_valid = 1'b0;
        wr_done  = 1'b0;
    endtask

    // Waits for the scoreboard to empty and the block to go ready; ready must
    // stay low while bytes are still outstanding.
    task automatic wait_drain(input string name);
        int  n;
        bit  early;
        n     = 0;
        early = 1'b0;
        while ((exp_q.size() != 0 || !ready) && n < 300) begin
            @(negedge clk);
            if (exp_q.size() != 0 && ready) early = 1'b1;
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout: %0d bytes outstanding, ready=%b", name, exp_q.size(), ready);
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL %s_ready: ready=1 while frame bytes outstanding, expected 0", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, expected 0", ready); end
        checks++;
        if (tx_wr !== 1'b0 || tx_data !== 8'h00 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: tx_wr=%b tx_data=%02h overrun=%b, expected 0/00/0", tx_wr, tx_data, overrun);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, expected 1", ready); end
    endtask

    task automatic test_read_frame();
        push_read(16'h3A5F);
        pulse(1'b1, 16'h3A5F, 1'b0);
        @(negedge clk);
        checks++;
        if (tx_wr !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL read_latency_hdr: tx_wr=%b ready=%b, expected 0/0", tx_wr, ready);
        end
        @(negedge clk);
        checks++;
        if (tx_wr !== 1'b1) begin errors++; $display("FAIL read_latency_first: tx_wr=%b, expected 1", tx_wr); end
        wait_drain("read");
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL read_overrun: got %b, expected 0", overrun); end
    endtask

    task automatic test_write_frame();
        int n;
        push_write();
        exp_b.push_back(8'h4B);
        exp_b.push_back(8'h0A);
        @(posedge clk); #1;
        wr_done   = 1'b1;
        wr_done_b = 1'b1;
        @(posedge clk); #1;
        wr_done   = 1'b0;
        wr_done_b = 1'b0;
        wait_drain("write");
        n = 0;
        while ((exp_b.size() != 0 || !ready_b) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL write_lf_timeout: %0d bytes outstanding, ready=%b", exp_b.size(), ready_b);
        end
    endtask

    task automatic test_back_to_back();
        push_read(16'h0009);
        push_write();
        pulse(1'b1, 16'h0009, 1'b1);
        wait_drain("b2b");
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b, expected 0", overrun); end
    endtask

    task automatic test_backpressure();
        bit bad;
        push_read(16'hFFFF);
        pulse(1'b1, 16'hFFFF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (tx_wr !== 1'b1 || tx_data !== 8'h44) begin
            errors++;
            $display("FAIL bp_hdr: tx_wr=%b tx_data=%02h, expected 1/44", tx_wr, tx_data);
        end
        tx_full = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx_wr !== 1'b0 || tx_data !== 8'h44) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: tx_wr=%b tx_data=%02h during tx_full, expected 0/44", tx_wr, tx_data);
        end
        checks++;
        if (exp_q.size() != 6) begin
            errors++;
            $display("FAIL bp_count: %0d bytes outstanding, expected 6", exp_q.size());
        end
        tx_full = 1'b0;
        wait_drain("bp");
    endtask

    task automatic test_overrun();
        push_read(16'h1234);
        pulse(1'b1, 16'h1234, 1'b0);
        repeat (3) @(posedge clk);
        pulse(1'b1, 16'hDEAD, 1'b0);
        @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_read: overrun=%b, expected 1", overrun); end
        push_write();
        pulse(1'b0, 16'h0, 1'b1);
        repeat (2) @(posedge clk);
        pulse(1'b0, 16'h0, 1'b1);
        wait_drain("ovr");
        repeat (10) @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: overrun=%b, expected 1", overrun); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        push_read(16'hABCD);
        pulse(1'b1, 16'hABCD, 1'b0);
        n = 0;
        while (exp_q.size() > 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL rst_mid_timeout: %0d bytes outstanding", exp_q.size()); end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready_low: got %b, expected 0", ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || overrun !== 1'b0 || tx_wr !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: ready=%b overrun=%b tx_wr=%b, expected 1/0/0", ready, overrun, tx_wr);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: ready=%b, expected 1", ready); end
        push_read(16'h7C20);
        pulse(1'b1, 16'h7C20, 1'b0);
        wait_drain("rst_fresh");
    endtask

    initial begin
        test_reset();
        test_read_frame();
        test_write_frame();
        test_back_to_back();
        test_backpressure();
        test_overrun();
        test_reset_mid_frame();
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
